temp_bcd_fmt: RTL and testbench
===============================

TEMP_BCD_FMT -- requirements
Module: temp_bcd_fmt

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: adc_valid  input  1  one-cycle strobe from the ADC stage; adc_code is valid in that cycle.
REQ-004 SHALL have port: adc_code  input  8  raw unsigned ADC sample.
REQ-005 SHALL have port: lcd_ready  input  1  LCD state machine accepts value when high.
REQ-006 SHALL have port: val_valid  output  1  value holds a complete result.
REQ-007 SHALL have port: value  output  24  three ASCII characters, hundreds in [23:16], ones in [7:0].
REQ-008 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port: ovr  output  1  sticky overrun flag.

Function
REQ-010 SHALL implement FSM states IDLE, SCALE, CONV, HOLD; busy = (state != IDLE).
REQ-011 IDLE: on adc_valid=1 at a rising edge, SHALL capture adc_code and go to SCALE.
REQ-012 SCALE: SHALL register temp = (code * 125) >> 6, 15-bit product, 9-bit result, range 0..498; SHALL go to CONV.
REQ-013 CONV: SHALL run a sequential shift-add-3 binary-to-BCD conversion, one bit per cycle, 9 cycles, with a 4-bit iteration counter.
REQ-014 After the 9th iteration, SHALL load value, assert val_valid, and go to HOLD.
REQ-015 Latency SHALL be exactly 11 rising edges from the accepting edge to val_valid=1.
REQ-016 Leading-zero blanking: hundreds=0 SHALL give 0x20.
REQ-017 Leading-zero blanking: hundreds=0 and tens=0 SHALL give tens=0x20.
REQ-018 The ones digit SHALL always be 0x30+digit.
REQ-019 HOLD: value and val_valid SHALL stay stable until an edge with lcd_ready=1; at that edge, val_valid SHALL clear and the FSM SHALL go to IDLE.
REQ-020 adc_valid while busy=1, including the handshake edge, SHALL be dropped and SHALL set ovr=1; the in-flight result SHALL be unaffected.
REQ-021 ovr SHALL clear only on reset.
REQ-022 lcd_ready while not in HOLD SHALL be ignored.
REQ-023 value SHALL retain the last result after the handshake until the next load.

Reset
REQ-024 rst=0 SHALL asynchronously force: state IDLE, val_valid=0, busy=0, ovr=0, value=0x202020, counters and accumulators 0.
REQ-025 Reset mid-CONV or mid-HOLD SHALL abort the operation with no result emitted.
REQ-026 After rst deasserts, the first adc_valid SHALL be accepted normally.

Configuration
REQ-027 Macro TEMP_AVG_EN SHALL enable 4-sample averaging when defined.
REQ-028 With TEMP_AVG_EN: IDLE SHALL add each accepted sample into a 10-bit accumulator with a 2-bit sample count; on the 4th sample, code = sum >> 2 SHALL enter SCALE and accumulator and count SHALL clear.
REQ-029 With TEMP_AVG_EN: latency SHALL count from the 4th sample's edge.
REQ-030 Without TEMP_AVG_EN: every accepted sample SHALL be converted; no accumulator logic SHALL exist.

Verification
REQ-031 Bench SHALL cover: adc_code 0x00 -> after 11 edges val_valid=1, value=0x202030 ("  0").
REQ-032 Bench SHALL cover: 0x80 -> 0x323530 ("250"); 0xFF -> 0x343938 ("498"); 0x05 -> 0x202039 ("  9").
REQ-033 Bench SHALL cover: lcd_ready held 0 for 20 cycles after val_valid -> value stable; lcd_ready=1 -> val_valid=0 next cycle, busy=0.
REQ-034 Bench SHALL cover: second adc_valid 3 cycles into CONV -> ovr=1, exactly one result; ovr stays 1 until rst=0.
REQ-035 Bench SHALL cover: rst=0 during CONV -> outputs at reset values immediately; no val_valid until a new sample completes.
REQ-036 Bench SHALL cover: with TEMP_AVG_EN, samples 0x10, 0x20, 0x30, 0x40 -> one result 0x203738 (" 78"); no result after the first three.

Source files
------------

// File: rtl/temp_bcd_fmt_if.sv
// Handshake/data bundle between the ADC stage, the formatter and the LCD driver.
// master: producer/consumer side (drives samples and lcd_ready)
// slave : formatter side (temp_bcd_fmt)
interface temp_bcd_fmt_if;
    logic        adc_valid;
    logic [7:0]  adc_code;
    logic        lcd_ready;
    logic        val_valid;
    logic [23:0] value;
    logic        busy;
    logic        ovr;

    modport master (
        output adc_valid, adc_code, lcd_ready,
        input  val_valid, value, busy, ovr
    );

    modport slave (
        input  adc_valid, adc_code, lcd_ready,
        output val_valid, value, busy, ovr
    );
endinterface

// File: rtl/temp_bcd_fmt.sv
// Temperature formatter: scales an 8-bit ADC code to 0..498, converts it to
// BCD with a sequential shift-add-3 loop and presents three ASCII characters
// with leading-zero blanking, held until the LCD driver accepts them.
// Optional feature: define TEMP_AVG_EN to average four samples per result.
module temp_bcd_fmt (
    input  logic           clk,
    input  logic           rst,
    temp_bcd_fmt_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SCALE, CONV, HOLD} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_code;
    logic [8:0]  r_bin;
    logic [11:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [23:0] r_value;
    logic        r_ovr;

    logic        w_start;
    logic [7:0]  w_code_in;
    logic [14:0] w_prod;
    logic [8:0]  w_temp;
    logic [11:0] w_adj;
    logic [7:0]  w_hund;
    logic [7:0]  w_tens;
    logic [7:0]  w_ones;

`ifdef TEMP_AVG_EN
    logic [9:0]  r_acc;
    logic [1:0]  r_smp;
    logic [9:0]  w_sum;

    assign w_sum     = r_acc + {2'b00, bus.adc_code};
    assign w_start   = (r_state == IDLE) && bus.adc_valid && (r_smp == 2'd3);
    assign w_code_in = 8'(w_sum >> 2);

    // Accumulate accepted samples; the 4th one launches a conversion and clears
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_smp <= '0;
        end else if ((r_state == IDLE) && bus.adc_valid) begin
            if (r_smp == 2'd3) begin
                r_acc <= '0;
                r_smp <= '0;
            end else begin
                r_acc <= w_sum;
                r_smp <= r_smp + 2'd1;
            end
        end
    end
`else
    assign w_start   = (r_state == IDLE) && bus.adc_valid;
    assign w_code_in = bus.adc_code;
`endif

    // temp = code * 125 / 64, max 255*125 = 31875 fits in 15 bits
    assign w_prod = {7'd0, r_code} * 15'd125;
    assign w_temp = 9'(w_prod >> 6);

    // Add-3 correction of every BCD digit that is 5 or more, ahead of the shift
    always_comb begin
        w_adj = r_bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    // ASCII digits with leading-zero blanking; ones digit always shown
    always_comb begin
        w_hund = (r_bcd[11:8] == 4'd0) ? 8'h20 : {4'h3, r_bcd[11:8]};
        w_tens = ((r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0)) ? 8'h20 : {4'h3, r_bcd[7:4]};
        w_ones = {4'h3, r_bcd[3:0]};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic; CONV spends 9 shift cycles plus one load cycle
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_state_nxt = SCALE;
            SCALE:   w_state_nxt = CONV;
            CONV:    if (r_cnt == 4'd9) w_state_nxt = HOLD;
            HOLD:    if (bus.lcd_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: capture, scale, shift-add-3 iterations, result load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code  <= '0;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_value <= 24'h202020;
        end else begin
            case (r_state)
                IDLE: if (w_start) r_code <= w_code_in;
                SCALE: begin
                    r_bin <= w_temp;
                    r_bcd <= '0;
                    r_cnt <= '0;
                end
                CONV: begin
                    if (r_cnt != 4'd9) begin
                        r_bcd <= 12'({w_adj, r_bin[8]});
                        r_bin <= r_bin << 1;
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_value <= {w_hund, w_tens, w_ones};
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun: any sample offered while not idle is lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                     r_ovr <= 1'b0;
        else if ((r_state != IDLE) && bus.adc_valid)  r_ovr <= 1'b1;
    end

    assign bus.val_valid = (r_state == HOLD);
    assign bus.busy      = (r_state != IDLE);
    assign bus.value     = r_value;
    assign bus.ovr       = r_ovr;

endmodule

// File: tb/tb_temp_bcd_fmt.sv
// Scoreboard bench for temp_bcd_fmt; covers the averaging build when
// TEMP_AVG_EN is defined.
module tb_temp_bcd_fmt;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_results;
    int   cyc;
    logic prev_vv;

    logic [23:0] exp_q[$];
    int          lat_q[$];

    int unsigned m_acc;
    int unsigned m_cnt;

    temp_bcd_fmt_if bus ();

    temp_bcd_fmt dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: integer scaling and decimal digit split
    function automatic logic [23:0] fmt_exp(input int unsigned code);
        int unsigned t, h, te, o;
        logic [7:0] ch, ct, co;
        t  = (code * 125) / 64;
        h  = t / 100;
        te = (t / 10) % 10;
        o  = t % 10;
        ch = (h == 0) ? 8'h20 : 8'(32'h30 + h);
        ct = (h == 0 && te == 0) ? 8'h20 : 8'(32'h30 + te);
        co = 8'(32'h30 + o);
        return {ch, ct, co};
    endfunction

    // Monitor: pop expectation on every rising val_valid
    always @(negedge clk) begin
        if (bus.val_valid && !prev_vv) begin
            n_results++;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                check("sb_value", {8'd0, bus.value}, {8'd0, exp_q.pop_front()});
                check("latency", 32'(cyc - lat_q.pop_front()), 32'd11);
            end
        end
        prev_vv = bus.val_valid;
    end

    task automatic send(input logic [7:0] c, input bit accept);
        @(negedge clk);
        bus.adc_valid = 1'b1;
        bus.adc_code  = c;
        if (accept) begin
`ifdef TEMP_AVG_EN
            m_acc += c;
            m_cnt++;
            if (m_cnt == 4) begin
                exp_q.push_back(fmt_exp(m_acc / 4));
                lat_q.push_back(cyc + 1);
                m_acc = 0;
                m_cnt = 0;
            end
`else
            exp_q.push_back(fmt_exp(c));
            lat_q.push_back(cyc + 1);
`endif
        end
        @(negedge clk);
        bus.adc_valid = 1'b0;
    endtask

    task automatic convert(input logic [7:0] c);
`ifdef TEMP_AVG_EN
        for (int i = 0; i < 4; i++) send(c, 1'b1);
`else
        send(c, 1'b1);
`endif
    endtask

    task automatic wait_result();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.val_valid) break;
        end
        check("result_timeout", {31'd0, bus.val_valid}, 32'd1);
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.lcd_ready = 1'b1;
        @(negedge clk);
        bus.lcd_ready = 1'b0;
        check("hs_valid", {31'd0, bus.val_valid}, 32'd0);
        check("hs_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    int n0;

    initial begin
        n_checks = 0; n_fail = 0; n_results = 0; cyc = 0; prev_vv = 1'b0;
        m_acc = 0; m_cnt = 0;
        rst = 1'b0;
        bus.adc_valid = 1'b0;
        bus.adc_code  = '0;
        bus.lcd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, bus.val_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_ovr", {31'd0, bus.ovr}, 32'd0);
        check("rst_value", {8'd0, bus.value}, 32'h202020);
        rst = 1'b1;

        // Zero input, long hold, then accept
        convert(8'h00);
        wait_result();
        check("val_00", {8'd0, bus.value}, 32'h202030);
        repeat (20) @(negedge clk);
        check("hold_value", {8'd0, bus.value}, 32'h202030);
        check("hold_valid", {31'd0, bus.val_valid}, 32'd1);
        handshake();
        check("retain_value", {8'd0, bus.value}, 32'h202030);

        // lcd_ready pulsed during conversion must be ignored
        convert(8'h80);
        @(negedge clk); bus.lcd_ready = 1'b1;
        @(negedge clk); bus.lcd_ready = 1'b0;
        wait_result();
        check("val_80", {8'd0, bus.value}, 32'h323530);
        handshake();

        convert(8'hFF);
        wait_result();
        check("val_FF", {8'd0, bus.value}, 32'h343938);
        handshake();

        convert(8'h05);
        wait_result();
        check("val_05", {8'd0, bus.value}, 32'h202039);
        handshake();

        // Overrun: extra sample three cycles into CONV
        n0 = n_results;
        convert(8'h40);
        repeat (2) @(negedge clk);
        send(8'h99, 1'b0);
        check("ovr_set", {31'd0, bus.ovr}, 32'd1);
        wait_result();
        handshake();
        repeat (20) @(negedge clk);
        check("ovr_one_result", 32'(n_results - n0), 32'd1);
        check("ovr_sticky", {31'd0, bus.ovr}, 32'd1);

        // Reset in the middle of CONV aborts the conversion
        convert(8'h80);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_valid", {31'd0, bus.val_valid}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_ovr", {31'd0, bus.ovr}, 32'd0);
        check("abort_value", {8'd0, bus.value}, 32'h202020);
        exp_q.delete();
        lat_q.delete();
        m_acc = 0; m_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        n0 = n_results;
        repeat (20) @(negedge clk);
        check("abort_no_result", 32'(n_results - n0), 32'd0);

        // Sample on the handshake edge is dropped and flags overrun
        convert(8'h05);
        wait_result();
        check("post_rst_val", {8'd0, bus.value}, 32'h202039);
        @(negedge clk);
        bus.lcd_ready = 1'b1;
        bus.adc_valid = 1'b1;
        bus.adc_code  = 8'h33;
        @(negedge clk);
        bus.lcd_ready = 1'b0;
        bus.adc_valid = 1'b0;
        check("hs_edge_ovr", {31'd0, bus.ovr}, 32'd1);
        n0 = n_results;
        repeat (20) @(negedge clk);
        check("hs_edge_dropped", 32'(n_results - n0), 32'd0);
        check("hs_edge_idle", {31'd0, bus.busy}, 32'd0);

`ifdef TEMP_AVG_EN
        // Four distinct samples averaged into one result
        n0 = n_results;
        send(8'h10, 1'b1); repeat (3) @(negedge clk);
        send(8'h20, 1'b1); repeat (3) @(negedge clk);
        send(8'h30, 1'b1);
        repeat (20) @(negedge clk);
        check("avg_no_early", 32'(n_results - n0), 32'd0);
        send(8'h40, 1'b1);
        wait_result();
        check("avg_value", {8'd0, bus.value}, 32'h203738);
        handshake();
        check("avg_one_result", 32'(n_results - n0), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
